// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths, bubble value and enable constants for the pipe_stage_reg slice.
package pipe_stage_reg_pkg;

    localparam int unsigned INS_BUS_W = 16;
    localparam int unsigned PC_DATA_W = 16;
    localparam logic [15:0] NOP_INS   = 16'h0800;

    localparam logic PAUSE = 1'b1;
    localparam logic CLEAR = 1'b1;

    function automatic logic [1:0] count_valid(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding slot: a valid bit plus a data register with load/clear.
module pipe_slot #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Clear only drops valid; data is kept so the PC stays visible while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= d;
        end
    end

    assign valid = valid_q;
    assign q     = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Fetch/decode stage register: two-entry (main + skid) elastic buffer with flush.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned        INS_W     = INS_BUS_W,
    parameter int unsigned        PC_W      = PC_DATA_W,
    parameter logic [INS_W-1:0]   EMPTY_INS = INS_W'(NOP_INS),
    parameter int unsigned        CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INS_W-1:0] in_ins,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INS_W-1:0] out_ins,
    output logic [PC_W-1:0]  out_pc,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned DW = INS_W + PC_W;

    logic          main_valid, skid_valid;
    logic [DW-1:0] main_q, skid_q, main_d;
    logic          main_load, main_clear, skid_load, skid_clear;
    logic          main_valid_d, skid_valid_d;
    logic          push, pop;
    logic [1:0]    occ_q;
    logic [CNT_W-1:0] stall_q;

    // in_ready comes straight from the skid valid flop; out_ready never reaches it.
    assign in_ready = !skid_valid;
    assign push     = in_valid && in_ready;
    assign pop      = main_valid && out_ready;

    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_d     = skid_valid ? skid_q : {in_ins, in_pc};
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            if (!main_valid) begin
                main_load = push;
            end else if (pop) begin
                main_load  = skid_valid || push;
                main_clear = !skid_valid && !push;
                skid_clear = skid_valid;
            end else begin
                skid_load = push;
            end
        end
    end

    always_comb begin
        main_valid_d = main_valid;
        skid_valid_d = skid_valid;
        if (main_clear) begin
            main_valid_d = 1'b0;
        end else if (main_load) begin
            main_valid_d = 1'b1;
        end
        if (skid_clear) begin
            skid_valid_d = 1'b0;
        end else if (skid_load) begin
            skid_valid_d = 1'b1;
        end
    end

    pipe_slot #(
        .W (DW)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    pipe_slot #(
        .W (DW)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     ({in_ins, in_pc}),
        .valid (skid_valid),
        .q     (skid_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q   <= 2'd0;
            stall_q <= '0;
        end else begin
            occ_q <= count_valid(main_valid_d, skid_valid_d);
            if (main_valid && !out_ready && stall_q != '1) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign out_valid = main_valid;
    assign out_ins   = main_valid ? main_q[DW-1:PC_W] : EMPTY_INS;
    assign out_pc    = main_q[PC_W-1:0];
    assign occupancy = occ_q;
    assign stall_cnt = stall_q;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter INS_W, default 16, SHALL set the instruction field width in bits.
REQ-002 Parameter PC_W, default 16, SHALL set the PC field width in bits.
REQ-003 Parameter EMPTY_INS, default 16'h0800 (NOP), SHALL set the bubble instruction value; its width SHALL be INS_W.
REQ-004 Parameter CNT_W, default 16, SHALL set the stall counter width.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port in_valid, input, 1 bit: upstream presents in_ins and in_pc.
REQ-008 Port in_ready, output, 1 bit: the stage can accept a word this cycle.
REQ-009 Port in_ins, input, INS_W bits: the fetched instruction.
REQ-010 Port in_pc, input, PC_W bits: the PC+1 value that accompanies in_ins.
REQ-011 Port flush, input, 1 bit: synchronous clear of all held entries.
REQ-012 Port out_valid, output, 1 bit: out_ins and out_pc are a valid entry.
REQ-013 Port out_ready, input, 1 bit: downstream consumes the entry this cycle.
REQ-014 Port out_ins, output, INS_W bits: the held instruction, or EMPTY_INS when out_valid=0.
REQ-015 Port out_pc, output, PC_W bits: the held PC value.
REQ-016 Port occupancy, output, 2 bits: the number of held entries (0..2).
REQ-017 Port stall_cnt, output, CNT_W bits: the saturating stall-cycle count.

Function
REQ-018 The storage SHALL be two entries, main and skid; main SHALL drive out_*, and skid SHALL be valid only when main is valid.
REQ-019 in_ready SHALL equal !skid_valid and SHALL be driven directly from a register, with no combinational path from out_ready.
REQ-020 A push SHALL be in_valid && in_ready; a pop SHALL be out_valid && out_ready.
REQ-021 From occupancy 0, a push SHALL load main, and out_valid SHALL rise on the next edge (latency 1).
REQ-022 From occupancy 1, push and pop together SHALL reload main, keeping occupancy 1.
REQ-023 From occupancy 1, a push without a pop SHALL load skid, raising occupancy to 2 and dropping in_ready on the next edge.
REQ-024 From occupancy 1, a pop without a push SHALL empty the stage.
REQ-025 At occupancy 2, no push SHALL be possible; a pop SHALL move skid into main, leaving occupancy 1.
REQ-026 Entries SHALL leave in FIFO order; no entry SHALL be lost or duplicated.
REQ-027 Flush SHALL have priority over push and pop: on the next edge both entries SHALL be invalid and occupancy SHALL be 0.
REQ-028 A word pushed in the same cycle as flush SHALL be discarded.
REQ-029 When out_valid=0, out_ins SHALL equal EMPTY_INS.
REQ-030 out_pc SHALL hold its last value across a flush and while empty.
REQ-031 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, saturate at all-ones, and not be cleared by flush.
REQ-032 occupancy SHALL be registered and consistent with main_valid + skid_valid on every cycle.

Reset
REQ-033 While rst=1, outputs SHALL be: out_valid=0, out_ins=EMPTY_INS, out_pc=0, occupancy=0, stall_cnt=0, in_ready=1.
REQ-034 Pushes presented while rst=1 SHALL be ignored.
REQ-035 Reset asserted mid-operation SHALL discard all held entries immediately, without waiting for a clock edge.

Structure
REQ-036 The shared define header SHALL hold the width macros (instruction bus, PC data), the EMPTY_INS NOP value, and the PAUSE/CLEAR enable constants.
REQ-037 One sub-module, pipe_slot (a valid bit plus an INS_W+PC_W data register with load and clear inputs), SHALL be instantiated twice, for main and skid.
REQ-038 The RTL SHALL contain no latches and no combinational path from in_valid to out_*.

Verification
REQ-039 Reset, then push ins=16'h1234, pc=16'h0005 with out_ready=1 -> next cycle out_valid=1, out_ins=16'h1234, out_pc=16'h0005, occupancy=1.
REQ-040 out_ready=0, push A then B -> occupancy=2, in_ready=0; a push of C is refused; raising out_ready -> A then B, in consecutive cycles.
REQ-041 At occupancy 2, assert flush together with in_valid=1 (D) -> next cycle occupancy=0, out_ins=16'h0800, D never appears.
REQ-042 With CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=4'hF and it stays there.
REQ-043 Assert rst asynchronously mid-cycle at occupancy 2 -> out_valid=0 and in_ready=1 before the next clock edge.
REQ-044 Random in_valid/out_ready for 10k cycles against a scoreboard -> output order equals input order, and occupancy never exceeds 2.
